// File: rtl/odd_parity_serial_tx.sv
// odd_parity_serial_tx: frames 4-bit nibbles as start, d0..d3, odd parity, stop
// on a single idle-high wire, each bit held CLKS_PER_BIT clocks.
`default_nettype none

module odd_parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    bit_q, bit_d;
  logic [3:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx_d always carries the value for the next bit slot, so tx is a pure flop.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == LAST_CNT);
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (in_valid && ready_q) begin
          shift_d = in_data;
          par_d   = ~^in_data;
          state_d = S_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = 2'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 2'd3) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 2'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign in_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_odd_parity_serial_tx.sv
// tb_odd_parity_serial_tx: directed checks of framing, timing, reset and parity
// on an N=4 and an N=1 instance of odd_parity_serial_tx.
`default_nettype none

module tb_odd_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       v;
  bit         sel1;

  logic in_valid4, in_ready4, tx4, busy4, done4;
  logic in_valid1, in_ready1, tx1, busy1, done1;
  logic w_tx, w_rdy, w_busy, w_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = 0;

  always #5 clk = ~clk;

  assign in_valid4 = v & ~sel1;
  assign in_valid1 = v & sel1;
  assign w_tx   = sel1 ? tx1 : tx4;
  assign w_rdy  = sel1 ? in_ready1 : in_ready4;
  assign w_busy = sel1 ? busy1 : busy4;
  assign w_done = sel1 ? done1 : done4;

  odd_parity_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid4),
    .in_ready(in_ready4), .tx(tx4), .busy(busy4), .done(done4)
  );

  odd_parity_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // exp[i] is frame bit i (0 = start, 5 = parity, 6 = stop).
  task automatic frame(input string name, input logic [3:0] d, input logic [6:0] exp,
                       input int n, input bit hold_valid, input bit scramble);
    in_data = d;
    v       = 1'b1;
    check_eq({name, " ready_before"}, 32'(w_rdy), 32'd1);
    step();
    if (!hold_valid) v = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < n; j++) begin
        if (scramble) begin
          in_data = 4'b1001;
          v       = j[0];
        end
        check_eq($sformatf("%s tx bit%0d cyc%0d", name, i, i*n + j + 1), 32'(w_tx), 32'(exp[i]));
        check_eq($sformatf("%s done_low cyc%0d", name, i*n + j + 1), 32'(w_done), 32'd0);
        if (j == 0) begin
          check_eq($sformatf("%s busy bit%0d", name, i), 32'(w_busy), 32'd1);
          check_eq($sformatf("%s ready_low bit%0d", name, i), 32'(w_rdy), 32'd0);
        end
        step();
      end
    end
    if (scramble) v = hold_valid;
    check_eq({name, " done_end"}, 32'(w_done), 32'd1);
    check_eq({name, " ready_end"}, 32'(w_rdy), 32'd1);
    check_eq({name, " busy_end"}, 32'(w_busy), 32'd0);
    check_eq({name, " tx_idle_end"}, 32'(w_tx), 32'd1);
    done_cyc = cyc;
  endtask

  initial begin
    logic [15:0] par_tab;
    logic [6:0]  exp;
    int          first_done;

    par_tab = 16'h9669;
    rst     = 1'b1;
    v       = 1'b0;
    in_data = 4'h0;
    sel1    = 1'b0;
    repeat (3) step();
    check_eq("reset tx", 32'(tx4), 32'd1);
    check_eq("reset in_ready", 32'(in_ready4), 32'd1);
    check_eq("reset busy", 32'(busy4), 32'd0);
    check_eq("reset done", 32'(done4), 32'd0);
    check_eq("reset tx n1", 32'(tx1), 32'd1);
    rst = 1'b0;

    // Idle with no valid: line stays high and no done appears.
    for (int k = 0; k < 50; k++) begin
      step();
      check_eq($sformatf("idle tx c%0d", k), 32'(tx4), 32'd1);
      check_eq($sformatf("idle ready c%0d", k), 32'(in_ready4), 32'd1);
      check_eq($sformatf("idle busy c%0d", k), 32'(busy4), 32'd0);
      check_eq($sformatf("idle done c%0d", k), 32'(done4 | done1), 32'd0);
    end

    frame("n4_1011", 4'b1011, 7'b1010110, 4, 1'b0, 1'b0);
    step();
    check_eq("after_1011 done_clears", 32'(done4), 32'd0);
    check_eq("after_1011 tx_idle", 32'(tx4), 32'd1);

    frame("b2b_0000", 4'b0000, 7'b1100000, 4, 1'b1, 1'b0);
    first_done = done_cyc;
    frame("b2b_1111", 4'b1111, 7'b1111110, 4, 1'b0, 1'b0);
    check_eq("b2b done_spacing", 32'(done_cyc - first_done), 32'd29);
    step();

    frame("hold_0110", 4'b0110, 7'b1101100, 4, 1'b0, 1'b1);
    step();
    check_eq("hold_0110 no_restart", 32'(busy4), 32'd0);

    // Abort a frame with reset asserted during cycle 10, with valid also high.
    in_data = 4'b1011;
    v       = 1'b1;
    step();
    v = 1'b0;
    repeat (9) step();
    check_eq("abort busy_before", 32'(busy4), 32'd1);
    rst = 1'b1;
    v   = 1'b1;
    step();
    rst = 1'b0;
    v   = 1'b0;
    check_eq("abort tx", 32'(tx4), 32'd1);
    check_eq("abort ready", 32'(in_ready4), 32'd1);
    check_eq("abort busy", 32'(busy4), 32'd0);
    check_eq("abort done", 32'(done4), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq($sformatf("abort quiet done c%0d", k), 32'(done4), 32'd0);
      check_eq($sformatf("abort quiet busy c%0d", k), 32'(busy4), 32'd0);
      check_eq($sformatf("abort quiet tx c%0d", k), 32'(tx4), 32'd1);
    end
    frame("after_abort_0001", 4'b0001, 7'b1000010, 4, 1'b0, 1'b0);
    step();

    sel1 = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] nib;
      nib = 4'(k);
      exp = {1'b1, par_tab[k], nib, 1'b0};
      frame($sformatf("n1_%0h", k), nib, exp, 1, 1'b0, 1'b0);
      step();
      check_eq($sformatf("n1_%0h done_clears", k), 32'(done1), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
